// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared bypass request/response types and bypass arbiter state enum
package std_cache_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic [1:0]  size;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [63:0] wdata;
  } bypass_req_t;
  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} arb_state_e;
endpackage

// File: rtl/std_bypass_rr_pick.sv
// std_bypass_rr_pick: first set req bit at or after ptr (wrapping) -> one-hot gnt, idx, any
module std_bypass_rr_pick #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] k;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % int'(N));
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = k;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/std_bypass_arbiter.sv
// std_bypass_arbiter: round-robin NR_PORTS req_i/rsp_o onto one bypass port req_o/rsp_i, one transaction outstanding
module std_bypass_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  bypass_req_t [NR_PORTS-1:0] req_i,
  output bypass_rsp_t [NR_PORTS-1:0] rsp_o,
  output bypass_req_t                req_o,
  input  bypass_rsp_t                rsp_i
);
  localparam int unsigned IW = NR_PORTS > 1 ? $clog2(NR_PORTS) : 1;
  arb_state_e    state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n, lat_idx, win_idx;
  logic [NR_PORTS-1:0] req_vec, win_gnt;
  logic          win_any, take, done;
  bypass_req_t   lat_req;
  always_comb begin
    req_vec = '0;
    for (int k = 0; k < NR_PORTS; k++) req_vec[k] = req_i[k].req;
  end
  std_bypass_rr_pick #(.N(NR_PORTS)) u_pick (
    .req(req_vec),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );
  assign take     = !rst_i && state == IDLE && win_any;
  assign done     = !rst_i && rsp_i.valid && ((state == SEND && rsp_i.gnt) || state == WAIT);
  assign rr_ptr_n = lat_idx == IW'(NR_PORTS - 1) ? '0 : lat_idx + IW'(1);
  always_comb begin
    state_n = state == IDLE ? (win_any ? SEND : IDLE)
            : state == SEND ? (rsp_i.gnt ? (rsp_i.valid ? IDLE : WAIT) : SEND)
            : (rsp_i.valid ? IDLE : WAIT);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lat_req <= '0;
      lat_idx <= '0;
    end else begin
      state <= state_n;
      if (done) rr_ptr <= rr_ptr_n;
      if (take) begin
        lat_req <= req_i[win_idx];
        lat_idx <= win_idx;
      end
    end
  end
  // responses are steered by the latched winner only, so rsp_i never reaches req_o
  always_comb begin
    req_o = '0;
    rsp_o = '0;
    if (!rst_i && state == SEND) begin
      req_o     = lat_req;
      req_o.req = 1'b1;
      req_o.id  = 4'(lat_idx);
    end
    if (take) rsp_o[win_idx].gnt = 1'b1;
    if (done) begin
      rsp_o[lat_idx].valid = 1'b1;
      rsp_o[lat_idx].rdata = rsp_i.rdata;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == IDLE)
      assert (!(rsp_i.gnt || rsp_i.valid))
      else $warning("std_bypass_arbiter: unexpected rsp_i handshake while idle");
  end
endmodule

// File: tb/tb_std_bypass_arbiter.sv
// tb_std_bypass_arbiter: scoreboard bench for std_bypass_arbiter acting as requesters and bypass memory
module tb_std_bypass_arbiter;
  import std_cache_pkg::*;
  localparam int N = 3;
  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  bypass_req_t [N-1:0] req_i;
  bypass_rsp_t [N-1:0] rsp_o;
  bypass_req_t         req_o;
  bypass_rsp_t         rsp_i;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  std_bypass_arbiter #(.NR_PORTS(N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req_i),
    .rsp_o(rsp_o),
    .req_o(req_o),
    .rsp_i(rsp_i)
  );
  function automatic logic [N-1:0] gnts();
    for (int k = 0; k < N; k++) gnts[k] = rsp_o[k].gnt;
  endfunction
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic test_reset();
    nxt();
    rst = 1'b1;
    req_i = '0;
    rsp_i = '0;
    repeat (2) nxt();
    req_i[0].req = 1'b1;
    #1;
    n_cmp++; if (req_o !== '0) begin n_err++; $display("FAIL reset_req_o: got %h want 0", req_o); end
    n_cmp++; if (rsp_o !== '0) begin n_err++; $display("FAIL reset_rsp_o: got %h want 0", rsp_o); end
    nxt();
    req_i = '0;
    rst = 1'b0;
    #1;
    n_cmp++; if (req_o !== '0 || rsp_o !== '0) begin n_err++; $display("FAIL post_reset: req_o=%h rsp_o=%h want 0", req_o, rsp_o); end
  endtask
  task automatic test_single_load();
    bypass_req_t r, e;
    exp_t x;
    r = '0; r.req = 1'b1; r.be = 8'hFF; r.size = 2'd3; r.addr = 64'h8000_0000;
    e = r; e.id = 4'd1;
    nxt();
    req_i[1] = r;
    #1;
    n_cmp++; if (gnts() !== 3'b010) begin n_err++; $display("FAIL load_gnt: got %b want 010", gnts()); end
    n_cmp++; if (req_o.req !== 1'b0) begin n_err++; $display("FAIL load_idle_req: got %b want 0", req_o.req); end
    nxt();
    req_i = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rsp_i.gnt = 1'b1;
      #1;
      n_cmp++; if (req_o !== e) begin n_err++; $display("FAIL load_send%0d: got %h want %h", c, req_o, e); end
      n_cmp++; if (gnts() !== 3'b000) begin n_err++; $display("FAIL load_send_gnt%0d: got %b want 000", c, gnts()); end
      nxt();
    end
    rsp_i = '0;
    #1;
    n_cmp++; if (req_o.req !== 1'b0 || rsp_o !== '0) begin n_err++; $display("FAIL load_wait: req=%b rsp_o=%h want 0", req_o.req, rsp_o); end
    nxt();
    nxt();
    rsp_i.valid = 1'b1;
    rsp_i.rdata = 64'hDEAD_BEEF;
    sb.push_back('{port: 1, data: 64'hDEAD_BEEF});
    #1;
    x = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rsp_o[k].valid !== (k == x.port) || rsp_o[k].rdata !== (k == x.port ? x.data : 64'd0)) begin
        n_err++; $display("FAIL load_rsp port%0d: got valid=%b rdata=%h want valid=%b rdata=%h", k, rsp_o[k].valid, rsp_o[k].rdata, k == x.port, k == x.port ? x.data : 64'd0);
      end
    end
    nxt();
    rsp_i = '0;
    #1;
    n_cmp++; if (rsp_o !== '0) begin n_err++; $display("FAIL load_one_shot: got %h want 0", rsp_o); end
  endtask
  task automatic test_round_robin();
    exp_t x;
    logic [63:0] d;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_i[k] = '0;
      req_i[k].req = 1'b1;
      req_i[k].addr = 64'h1000 * 64'(k + 1);
    end
    for (int t = 0; t < 6; t++) begin
      #1;
      n_cmp++; if (gnts() !== 3'(1 << (t % 3))) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", t, gnts(), 3'(1 << (t % 3))); end
      nxt();
      d = 64'hA0 + 64'(t);
      rsp_i.gnt = 1'b1;
      rsp_i.valid = 1'b1;
      rsp_i.rdata = d;
      sb.push_back('{port: t % 3, data: d});
      #1;
      n_cmp++; if (req_o.id !== 4'(t % 3) || req_o.addr !== 64'h1000 * 64'(t % 3 + 1)) begin n_err++; $display("FAIL rr_req%0d: got id=%0d addr=%h want id=%0d", t, req_o.id, req_o.addr, t % 3); end
      n_cmp++; if (gnts() !== 3'b000) begin n_err++; $display("FAIL rr_send_gnt%0d: got %b want 000", t, gnts()); end
      x = sb.pop_front();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (rsp_o[k].valid !== (k == x.port) || rsp_o[k].rdata !== (k == x.port ? x.data : 64'd0)) begin
          n_err++; $display("FAIL rr_rsp%0d port%0d: got valid=%b rdata=%h want valid=%b rdata=%h", t, k, rsp_o[k].valid, rsp_o[k].rdata, k == x.port, k == x.port ? x.data : 64'd0);
        end
      end
      nxt();
      rsp_i = '0;
    end
    req_i = '0;
  endtask
  task automatic test_stall();
    bypass_req_t r, e;
    exp_t x;
    r = '0; r.req = 1'b1; r.be = 8'hFF; r.size = 2'd2; r.addr = 64'h1234_5678;
    e = r; e.id = 4'd2;
    nxt();
    req_i[2] = r;
    #1;
    n_cmp++; if (gnts() !== 3'b100) begin n_err++; $display("FAIL stall_gnt: got %b want 100", gnts()); end
    nxt();
    req_i[0].req = 1'b1;
    req_i[1].req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if (req_o !== e) begin n_err++; $display("FAIL stall_req%0d: got %h want %h", c, req_o, e); end
      n_cmp++; if (gnts() !== 3'b000) begin n_err++; $display("FAIL stall_gnt%0d: got %b want 000", c, gnts()); end
      nxt();
    end
    req_i = '0;
    rsp_i.gnt = 1'b1;
    rsp_i.valid = 1'b1;
    rsp_i.rdata = 64'h5555_AAAA;
    sb.push_back('{port: 2, data: 64'h5555_AAAA});
    #1;
    x = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rsp_o[k].valid !== (k == x.port) || rsp_o[k].rdata !== (k == x.port ? x.data : 64'd0)) begin
        n_err++; $display("FAIL stall_rsp port%0d: got valid=%b rdata=%h want valid=%b rdata=%h", k, rsp_o[k].valid, rsp_o[k].rdata, k == x.port, k == x.port ? x.data : 64'd0);
      end
    end
    nxt();
    rsp_i = '0;
  endtask
  task automatic test_reset_in_wait();
    exp_t x;
    nxt();
    req_i[1] = '0;
    req_i[1].req = 1'b1;
    req_i[1].addr = 64'h40;
    #1;
    n_cmp++; if (gnts() !== 3'b010) begin n_err++; $display("FAIL rw_gnt: got %b want 010", gnts()); end
    nxt();
    req_i = '0;
    rsp_i.gnt = 1'b1;
    #1;
    n_cmp++; if (req_o.req !== 1'b1) begin n_err++; $display("FAIL rw_send: got %b want 1", req_o.req); end
    nxt();
    rsp_i = '0;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_o !== '0 || rsp_o !== '0) begin n_err++; $display("FAIL rw_in_reset: req_o=%h rsp_o=%h want 0", req_o, rsp_o); end
    nxt();
    rst = 1'b0;
    nxt();
    rsp_i.valid = 1'b1;
    rsp_i.rdata = 64'hBAD;
    #1;
    n_cmp++; if (req_o !== '0 || rsp_o !== '0) begin n_err++; $display("FAIL rw_late_valid: req_o=%h rsp_o=%h want 0", req_o, rsp_o); end
    nxt();
    rsp_i = '0;
    for (int k = 0; k < N; k++) req_i[k].req = 1'b1;
    #1;
    n_cmp++; if (gnts() !== 3'b001) begin n_err++; $display("FAIL rw_ptr_gnt: got %b want 001", gnts()); end
    nxt();
    req_i = '0;
    rsp_i.gnt = 1'b1;
    rsp_i.valid = 1'b1;
    rsp_i.rdata = 64'h77;
    sb.push_back('{port: 0, data: 64'h77});
    #1;
    n_cmp++; if (req_o.id !== 4'd0) begin n_err++; $display("FAIL rw_id: got %0d want 0", req_o.id); end
    x = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rsp_o[k].valid !== (k == x.port) || rsp_o[k].rdata !== (k == x.port ? x.data : 64'd0)) begin
        n_err++; $display("FAIL rw_rsp port%0d: got valid=%b rdata=%h want valid=%b rdata=%h", k, rsp_o[k].valid, rsp_o[k].rdata, k == x.port, k == x.port ? x.data : 64'd0);
      end
    end
    nxt();
    rsp_i = '0;
  endtask
  task automatic test_store();
    bypass_req_t r, e;
    exp_t x;
    r = '0; r.req = 1'b1; r.we = 1'b1; r.be = 8'h0F; r.size = 2'd3;
    r.addr = 64'h100; r.wdata = 64'h1122_3344_5566_7788;
    e = r; e.id = 4'd0;
    nxt();
    req_i[0] = r;
    #1;
    n_cmp++; if (gnts() !== 3'b001) begin n_err++; $display("FAIL store_gnt: got %b want 001", gnts()); end
    nxt();
    req_i = '0;
    rsp_i.gnt = 1'b1;
    rsp_i.valid = 1'b1;
    rsp_i.rdata = 64'd0;
    sb.push_back('{port: 0, data: 64'd0});
    #1;
    n_cmp++; if (req_o.we !== 1'b1 || req_o.be !== 8'h0F || req_o.wdata !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL store_fields: got we=%b be=%h wdata=%h want 1 0f 1122334455667788", req_o.we, req_o.be, req_o.wdata); end
    n_cmp++; if (req_o !== e) begin n_err++; $display("FAIL store_req: got %h want %h", req_o, e); end
    x = sb.pop_front();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (rsp_o[k].valid !== (k == x.port) || rsp_o[k].rdata !== (k == x.port ? x.data : 64'd0)) begin
        n_err++; $display("FAIL store_rsp port%0d: got valid=%b rdata=%h want valid=%b rdata=%h", k, rsp_o[k].valid, rsp_o[k].rdata, k == x.port, k == x.port ? x.data : 64'd0);
      end
    end
    nxt();
    rsp_i = '0;
  endtask
  task automatic test_idle_valid();
    nxt();
    rsp_i.gnt = 1'b1;
    rsp_i.valid = 1'b1;
    rsp_i.rdata = '1;
    #1;
    n_cmp++; if (rsp_o !== '0 || req_o !== '0) begin n_err++; $display("FAIL idle_valid: rsp_o=%h req_o=%h want 0", rsp_o, req_o); end
    nxt();
    rsp_i = '0;
    #1;
    n_cmp++; if (rsp_o !== '0 || req_o !== '0) begin n_err++; $display("FAIL idle_after: rsp_o=%h req_o=%h want 0", rsp_o, req_o); end
  endtask
  initial begin
    rst = 1'b1;
    req_i = '0;
    rsp_i = '0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_stall();
    test_reset_in_wait();
    test_store();
    test_idle_valid();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
